// File: rtl/sort_pkg.sv
// Shared types and constants for the 10-word streaming sort controller.
package sort_pkg;
  localparam int N = 10;
  localparam int W = 32;
  typedef logic [W-1:0] data_t;
  typedef enum logic [1:0] {FILL, SORT, DRAIN} sort_ctrl_state_e;
  localparam data_t PAD_VALUE = '1;
  localparam logic [3:0] N4 = 4'(N);
endpackage

// File: rtl/sort_10_29_8.sv
// Purely combinational ascending sorter for N unsigned words.
// Odd-even transposition network: N alternating compare-exchange layers.
module sort_10_29_8
  import sort_pkg::*;
(
  input  data_t [N-1:0] din,
  output data_t [N-1:0] dout
);
  always_comb begin
    data_t v [N];
    data_t t;
    t = '0;
    for (int i = 0; i < N; i++) v[i] = din[i];
    for (int s = 0; s < N; s++)
      for (int i = s % 2; i + 1 < N; i += 2)
        if (v[i] > v[i+1]) begin
          t      = v[i];
          v[i]   = v[i+1];
          v[i+1] = t;
        end
    dout = '0;
    for (int i = 0; i < N; i++) dout[i] = v[i];
  end
endmodule

// File: rtl/sort_10_stream_ctrl.sv
// Streaming wrapper: collect N words, sort in one cycle, drain ascending.
// Build option SORT_STREAM_FLUSH_EN enables closing a partial batch with flush.
module sort_10_stream_ctrl
  import sort_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  data_t in_data,
  output logic  in_ready,
  input  logic  flush,
  output logic  out_valid,
  output data_t out_data,
  output logic  out_last,
  input  logic  out_ready,
  output logic  busy
);
  sort_ctrl_state_e state;
  logic [3:0] cnt, idx, len;
  data_t [N-1:0] slot, obuf, sorted;
  logic acc, fill_done, pad_go;

  sort_10_29_8 u_sort (.din(slot), .dout(sorted));

  assign in_ready  = (state == FILL) && !rst;
  assign busy      = (state != FILL);
  assign out_data  = obuf[idx];
  assign out_last  = out_valid && (idx == len - 4'd1);
  assign acc       = in_valid && in_ready;
  assign fill_done = acc && (cnt == N4 - 4'd1);

`ifdef SORT_STREAM_FLUSH_EN
  // A flush closes the batch only if it would hold at least one word.
  assign pad_go = flush && (state == FILL) && (acc || cnt != 4'd0) && !fill_done;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign pad_go = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      idx       <= '0;
      len       <= '0;
      out_valid <= 1'b0;
      slot      <= '0;
      obuf      <= '0;
    end else begin
      case (state)
        FILL: begin
          // Incoming word wins its slot; everything above it becomes padding.
          for (int i = 0; i < N; i++)
            if (acc && cnt == 4'(i)) slot[i] <= in_data;
            else if (pad_go && 4'(i) >= cnt) slot[i] <= PAD_VALUE;
          if (fill_done) begin
            len   <= N4;
            cnt   <= '0;
            state <= SORT;
          end else if (pad_go) begin
            len   <= acc ? cnt + 4'd1 : cnt;
            cnt   <= '0;
            state <= SORT;
          end else if (acc) begin
            cnt <= cnt + 4'd1;
          end
        end
        SORT: begin
          obuf      <= sorted;
          idx       <= '0;
          out_valid <= 1'b1;
          state     <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx == len - 4'd1) begin
              out_valid <= 1'b0;
              idx       <= '0;
              state     <= FILL;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_10_stream_ctrl.sv
// Self-checking bench for sort_10_stream_ctrl: vector table plus scoreboard.
module tb_sort_10_stream_ctrl;
  import sort_pkg::*;

  logic  clk = 1'b0;
  logic  rst, in_valid, flush, out_ready;
  logic  in_ready, out_valid, out_last, busy;
  data_t in_data, out_data;

  always #5 clk = ~clk;

  sort_10_stream_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy)
  );

  typedef struct { data_t d; logic last; } exp_t;
  typedef struct { data_t din [10]; data_t exp [10]; int rmode; bit lat; } vec_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0, n_pop = 0;
  int   rmode = 0;
  logic man_ready = 1'b0;
  bit   gap_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void msort(input data_t a [10], output data_t r [10]);
    data_t t;
    int j;
    r = a;
    for (int i = 1; i < 10; i++) begin
      t = r[i];
      j = i - 1;
      while (j >= 0 && r[j] > t) begin
        r[j+1] = r[j];
        j--;
      end
      r[j+1] = t;
    end
  endfunction

  task automatic push_exp(input data_t e [10], input int len);
    exp_t x;
    for (int i = 0; i < len; i++) begin
      x.d = e[i];
      x.last = (i == len - 1);
      sb.push_back(x);
    end
  endtask

  // All driver tasks start and end at posedge+1.
  task automatic send_word(input data_t d, input bit fl = 1'b0);
    int t = 0;
    int g = gap_en ? int'($urandom_range(0, 2)) : 0;
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    do begin @(negedge clk); t++; end while (!in_ready && t < 300);
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic send_batch(input data_t din [10], input data_t exp [10], input bit lat);
    for (int i = 0; i < 10; i++) send_word(din[i]);
    push_exp(exp, 10);
    if (lat) begin
      @(negedge clk);
      chk("lat_sort_valid", out_valid, 0);
      chk("lat_sort_busy", busy, 1);
      @(negedge clk);
      chk("lat_first_valid", out_valid, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Downstream ready generator; updates at posedge+2 so main-loop edits at +1 are seen.
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph % 3 == 0); ph++; end
        2: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = man_ready;
      endcase
    end
  end

  // Output monitor: scoreboard pops, stall stability, no input accept while busy.
  initial begin
    bit    stall;
    data_t sd;
    logic  sl;
    exp_t  e;
    stall = 1'b0; sd = '0; sl = 1'b0;
    forever begin
      @(negedge clk);
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, sd);
        chk("stall_last", out_last, sl);
      end
      if (busy) chk("in_ready_busy", in_ready, 0);
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: got %h expected no word", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.last);
        end
      end
      stall = out_valid && !out_ready && !rst;
      sd = out_data;
      sl = out_last;
    end
  end

  initial begin
    vec_t  tbl [4];
    data_t a [10], ea [10], b [10], eb [10];
    int    t, low, p0;

    tbl[0].din = '{9, 3, 7, 0, 5, 1, 8, 2, 6, 4};
    tbl[0].exp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    tbl[0].rmode = 0; tbl[0].lat = 1'b1;
    tbl[1].din = '{9, 3, 7, 0, 5, 1, 8, 2, 6, 4};
    tbl[1].exp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    tbl[1].rmode = 1; tbl[1].lat = 1'b0;
    tbl[2].din = '{32'h8000_0000, 5, 32'hFFFF_FFFF, 5, 0, 32'h7FFF_FFFF, 1,
                   32'hFFFF_FFFE, 2, 32'h8000_0001};
    tbl[2].exp = '{0, 1, 2, 5, 5, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001,
                   32'hFFFF_FFFE, 32'hFFFF_FFFF};
    tbl[2].rmode = 2; tbl[2].lat = 1'b0;
    tbl[3].din = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
    tbl[3].exp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    tbl[3].rmode = 0; tbl[3].lat = 1'b0;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) begin
      rmode = tbl[k].rmode;
      send_batch(tbl[k].din, tbl[k].exp, tbl[k].lat);
      in_valid = 1'b0;
      wait_drain("table_drained");
    end

    // Back-to-back batches; busy must stay low only for the 10 fill cycles.
    rmode = 0;
    a = '{3, 1, 2, 0, 9, 8, 4, 7, 5, 6};
    msort(a, ea);
    for (int i = 0; i < 10; i++) begin b[i] = 32'hFFFF_FFFF; eb[i] = 32'hFFFF_FFFF; end
    t = 0; low = 0;
    fork
      begin
        send_batch(a, ea, 1'b0);
        send_batch(b, eb, 1'b0);
        in_valid = 1'b0;
      end
      begin
        do begin @(negedge clk); t++; end while (!busy && t < 500);
        do begin @(negedge clk); t++; end while (busy && t < 500);
        while (!busy && t < 500) begin low++; @(negedge clk); t++; end
        chk("b2b_idle_cycles", low, 10);
      end
    join
    wait_drain("b2b_drained");

`ifdef SORT_STREAM_FLUSH_EN
    send_word(40); send_word(10); send_word(30);
    in_valid = 1'b0;
    a = '{10, 30, 40, 0, 0, 0, 0, 0, 0, 0};
    push_exp(a, 3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_drain("flush3_drained");
    send_word(5); send_word(2);
    a = '{2, 5, 7, 0, 0, 0, 0, 0, 0, 0};
    push_exp(a, 3);
    send_word(7, 1'b1);
    in_valid = 1'b0;
    wait_drain("flush_acc_drained");
`else
    a = '{40, 10, 30, 6, 99, 1, 77, 3, 50, 2};
    msort(a, ea);
    for (int i = 0; i < 3; i++) send_word(a[i]);
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ignored_busy", busy, 0);
    @(posedge clk); #1;
    for (int i = 3; i < 10; i++) send_word(a[i]);
    push_exp(ea, 10);
    in_valid = 1'b0;
    wait_drain("flush_ignored_drained");
`endif

    // Flush on an empty batch produces nothing.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flush_empty_busy", busy, 0);
    end
    @(posedge clk); #1;

    // Reset during drain after 4 words.
    rmode = 3; man_ready = 1'b0;
    a = '{500, 20, 300, 40, 100, 60, 700, 80, 900, 10};
    msort(a, ea);
    send_batch(a, ea, 1'b0);
    in_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 50);
    chk("rd_valid", out_valid, 1);
    @(posedge clk); #1;
    man_ready = 1'b1;
    p0 = n_pop;
    repeat (4) @(posedge clk);
    #1;
    man_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rd_pops", n_pop - p0, 4);
    chk("rd_in_ready_rst", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rd_out_valid", out_valid, 0);
    chk("rd_busy", busy, 0);
    chk("rd_out_last", out_last, 0);
    chk("rd_out_data", out_data, 0);
    @(posedge clk); #1;
    rmode = 0;
    a = '{7, 77, 17, 27, 37, 47, 57, 67, 87, 97};
    msort(a, ea);
    send_batch(a, ea, 1'b0);
    in_valid = 1'b0;
    wait_drain("rd_new_drained");

    // Randomized batches with input gaps and random downstream ready.
    gap_en = 1'b1; rmode = 2;
    for (int bt = 0; bt < 200; bt++) begin
      for (int i = 0; i < 10; i++)
        a[i] = (bt % 2 == 0) ? data_t'($urandom) : data_t'($urandom_range(0, 15));
      msort(a, ea);
      send_batch(a, ea, 1'b0);
    end
    in_valid = 1'b0;
    wait_drain("rand_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
